// File: rtl/channel_scheduler.sv
// Round-robin scheduler: per-channel one-deep sample holding registers drained
// onto a single output, with a minimum spacing between output strobes.
module channel_scheduler #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int GAP      = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH*CHANNELS-1:0]     in,
   input  logic [CHANNELS-1:0]           in_valid,
   input  logic                          overrun_clear,
   output logic [WIDTH-1:0]              out,
   output logic                          out_valid,
   output logic [$clog2(CHANNELS)-1:0]   out_channel,
   output logic [CHANNELS-1:0]           overrun
);

   localparam int IDX_W = $clog2(CHANNELS);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   // Handshake: no back-pressure. out_valid is a one-cycle strobe; out and
   // out_channel are meaningful only while it is high and hold otherwise.

   logic [WIDTH-1:0]    hold_q [CHANNELS];
   logic [WIDTH-1:0]    hold_d [CHANNELS];
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] overrun_q, overrun_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [WIDTH-1:0]    out_q, out_d;
   logic [IDX_W-1:0]    out_channel_q, out_channel_d;
   logic                out_valid_q, out_valid_d;

   logic                grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [CHANNELS-1:0] grant_oh;

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                 input int unsigned     offset);
      int unsigned sum;
      sum = 32'(base) + offset;
      return IDX_W'(sum % CHANNELS);
   endfunction

   // Scan from farthest to nearest so the last hit is the first pending
   // channel at or after ptr in wrap-around order.
   always_comb begin
      grant_idx = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (pending_q[rr_index(ptr_q, unsigned'(k))]) begin
            grant_idx = rr_index(ptr_q, unsigned'(k));
         end
      end
   end

   assign grant    = (gap_q == '0) && (pending_q != '0);
   assign grant_oh = grant ? (CHANNELS'(1) << grant_idx) : '0;

   always_comb begin
      pending_d = (pending_q & ~grant_oh) | in_valid;
      // A fresh set beats a simultaneous clear for the same bit.
      overrun_d = (overrun_clear ? '0 : overrun_q) | (in_valid & pending_q & ~grant_oh);
      for (int i = 0; i < CHANNELS; i++) begin
         hold_d[i] = in_valid[i] ? in[WIDTH*i +: WIDTH] : hold_q[i];
      end
      out_d         = out_q;
      out_channel_d = out_channel_q;
      out_valid_d   = grant;
      ptr_d         = ptr_q;
      gap_d         = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
      if (grant) begin
         out_d         = hold_q[grant_idx];
         out_channel_d = grant_idx;
         ptr_d         = (grant_idx == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
         gap_d         = GAP_W'(GAP - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            hold_q[i] <= '0;
         end
         pending_q     <= '0;
         overrun_q     <= '0;
         ptr_q         <= '0;
         gap_q         <= '0;
         out_q         <= '0;
         out_channel_q <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            hold_q[i] <= hold_d[i];
         end
         pending_q     <= pending_d;
         overrun_q     <= overrun_d;
         ptr_q         <= ptr_d;
         gap_q         <= gap_d;
         out_q         <= out_d;
         out_channel_q <= out_channel_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign out         = out_q;
   assign out_channel = out_channel_q;
   assign out_valid   = out_valid_q;
   assign overrun     = overrun_q;

endmodule
